hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_control_unit_sat_counter.sv | 26 ++
 rtl/hazard_control_unit.sv | 133 +++++++++++++
 tb/tb_hazard_control_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_e;

    localparam int DEFAULT_TIMEOUT_LIMIT = 255;
    localparam int DEFAULT_CNT_W         = 16;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with async reset and synchronous clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush control for a 5-stage pipeline: load-use, taken branch,
// and data-memory wait with timeout fault.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_LIMIT = DEFAULT_TIMEOUT_LIMIT,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             EX_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    localparam int WAIT_W = $clog2(TIMEOUT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_LIMIT);

    state_e            r_state;
    state_e            w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_next;
    logic              r_mem_timeout;
    logic              w_load_use;
    logic              w_release;

    assign w_load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                        ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    always_comb begin
        w_next_state = r_state;
        w_wait_next  = r_wait_cnt;
        w_release    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    w_next_state = ST_MEM_WAIT;
                    w_wait_next  = WAIT_W'(1);
                end else begin
                    w_release = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    w_release    = 1'b1;
                    w_next_state = ST_RUN;
                    w_wait_next  = '0;
                end else if (r_wait_cnt == WAIT_LIMIT) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_wait_next = r_wait_cnt + WAIT_W'(1);
                end
            end
            ST_FAULT: begin
                w_next_state = ST_FAULT;
            end
            default: begin
                w_next_state = ST_RUN;
                w_wait_next  = '0;
            end
        endcase
    end

    // Released pipeline: branch flush outranks the load-use bubble.
    always_comb begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_write  = 1'b0;
        EX_MEM_write = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        if (w_release && !rst) begin
            PC_write     = 1'b1;
            IF_ID_write  = 1'b1;
            ID_EX_write  = 1'b1;
            EX_MEM_write = 1'b1;
            if (EX_branch_taken) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end else if (w_load_use) begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_wait_cnt    <= w_wait_next;
            r_mem_timeout <= r_mem_timeout | (w_next_state == ST_FAULT);
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (!PC_write),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (IF_ID_flush),
        .count (flush_count)
    );

    assign mem_timeout = r_mem_timeout;
    assign state       = r_state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: vector table, corner sequences, random vs model.
module tb_hazard_control_unit;

    localparam int TL = 4;
    localparam int CW = 3;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mr;
    logic [4:0]    rd, rs1, rs2;
    logic          br, req, rdy;
    logic          PC_write, IF_ID_write, ID_EX_write, EX_MEM_write;
    logic          IF_ID_flush, ID_EX_flush, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [1:0]    state;

    hazard_control_unit #(.TIMEOUT_LIMIT(TL), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_EX_MemRead   (mr),
        .ID_EX_rd        (rd),
        .IF_ID_rs1       (rs1),
        .IF_ID_rs2       (rs2),
        .EX_branch_taken (br),
        .dmem_req        (req),
        .dmem_ready      (rdy),
        .PC_write        (PC_write),
        .IF_ID_write     (IF_ID_write),
        .ID_EX_write     (ID_EX_write),
        .EX_MEM_write    (EX_MEM_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .state           (state)
    );

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    bit m_wait, m_fault;
    int m_waited, m_stall, m_flush;

    typedef struct {
        logic       mr;
        logic [4:0] rd, rs1, rs2;
        logic       br, req, rdy;
        logic [5:0] ctl;
        logic [1:0] st_after;
        int         stall_after;
        int         flush_after;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [5:0] ctl_now();
        return {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
                IF_ID_flush, ID_EX_flush};
    endfunction

    function automatic logic [14:0] snap();
        return {ctl_now(), mem_timeout, state, stall_cycles, flush_count};
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic a, input logic [4:0] b, input logic [4:0] c,
                          input logic [4:0] d, input logic e, input logic f,
                          input logic g);
        mr = a; rd = b; rs1 = c; rs2 = d; br = e; req = f; rdy = g;
    endtask

    task automatic model_reset();
        m_wait = 0; m_fault = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Expected enables/flushes from the rules, given current inputs.
    function automatic logic [5:0] model_ctl();
        bit lu;
        lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        if (m_fault) return 6'b0000_00;
        if (m_wait && !rdy) return 6'b0000_00;
        if (!m_wait && req && !rdy) return 6'b0000_00;
        if (br) return 6'b1111_11;
        if (lu) return 6'b0011_01;
        return 6'b1111_00;
    endfunction

    function automatic logic [14:0] model_snap();
        logic [1:0] st;
        st = m_fault ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
        return {model_ctl(), logic'(m_fault), st, CW'(m_stall), CW'(m_flush)};
    endfunction

    task automatic model_step(input logic [5:0] ctl);
        if (!ctl[5] && m_stall < SAT) m_stall++;
        if (ctl[1] && m_flush < SAT) m_flush++;
        if (m_fault) begin
        end else if (!m_wait) begin
            if (req && !rdy) begin
                m_wait = 1; m_waited = 1;
            end
        end else if (rdy) begin
            m_wait = 0;
        end else if (m_waited == TL) begin
            m_fault = 1; m_wait = 0;
        end else begin
            m_waited++;
        end
    endtask

    initial begin
        vecs[0]  = '{0, 5, 1, 2, 0, 0, 0, 6'b1111_00, 0, 0, 0};
        vecs[1]  = '{1, 5, 1, 5, 0, 0, 0, 6'b0011_01, 0, 1, 0};
        vecs[2]  = '{1, 7, 7, 3, 0, 0, 0, 6'b0011_01, 0, 1, 0};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 6'b1111_00, 0, 0, 0};
        vecs[4]  = '{0, 9, 9, 9, 0, 0, 0, 6'b1111_00, 0, 0, 0};
        vecs[5]  = '{1, 5, 1, 5, 1, 0, 0, 6'b1111_11, 0, 0, 1};
        vecs[6]  = '{0, 3, 1, 2, 1, 0, 1, 6'b1111_11, 0, 0, 1};
        vecs[7]  = '{1, 5, 5, 2, 1, 1, 0, 6'b0000_00, 1, 1, 0};
        vecs[8]  = '{0, 3, 1, 2, 0, 0, 0, 6'b1111_00, 0, 0, 0};
        vecs[9]  = '{1, 4, 1, 4, 0, 1, 1, 6'b0011_01, 0, 1, 0};
        vecs[10] = '{0, 3, 1, 2, 1, 0, 1, 6'b1111_11, 0, 0, 1};

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("reset_state", 16'(snap()), 16'd0);
        set_in(1, 5, 5, 5, 1, 0, 1);
        #1;
        check("reset_outputs_held", 16'(snap()), 16'd0);
        tick();
        rst = 1'b0;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            do_reset();
            set_in(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].br, vecs[i].req, vecs[i].rdy);
            #3;
            check($sformatf("vec%0d_ctl", i), 16'(ctl_now()), 16'(vecs[i].ctl));
            tick();
            check($sformatf("vec%0d_after", i),
                  16'({state, stall_cycles, flush_count}),
                  16'({vecs[i].st_after, CW'(vecs[i].stall_after),
                       CW'(vecs[i].flush_after)}));
        end

        // Memory wait: 3 frozen cycles, release on the 4th
        do_reset();
        set_in(1, 5, 5, 0, 1, 1, 0);
        for (int c = 0; c < 3; c++) begin
            #3;
            check($sformatf("wait_freeze%0d", c), 16'(ctl_now()), 16'd0);
            tick();
            check($sformatf("wait_state%0d", c), 16'(state), 16'd1);
        end
        rdy = 1'b1;
        #3;
        check("wait_release", 16'(ctl_now()), 16'(6'b1111_11));
        tick();
        check("wait_done", 16'({state, stall_cycles}), 16'({2'd0, CW'(3)}));

        // Timeout into FAULT, inputs ignored, async reset out
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < TL; c++) tick();
        check("pre_fault", 16'({mem_timeout, state}), 16'({1'b0, 2'd1}));
        tick();
        check("fault", 16'({mem_timeout, state}), 16'({1'b1, 2'd2}));
        set_in(1, 5, 5, 5, 1, 0, 1);
        tick();
        #2;
        check("fault_ignores", 16'({ctl_now(), mem_timeout, state}),
              16'({6'b0, 1'b1, 2'd2}));
        rst = 1'b1;
        #1;
        check("async_rst_fault", 16'(snap()), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Async reset in the middle of MEM_WAIT
        set_in(0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_wait", 16'(snap()), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // ready at the timeout edge wins over the fault
        set_in(0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < TL; c++) tick();
        rdy = 1'b1;
        #3;
        check("limit_ready_ctl", 16'(ctl_now()), 16'(6'b1111_00));
        tick();
        check("limit_ready_state", 16'({mem_timeout, state}), 16'd0);

        // Stall counter saturation
        do_reset();
        set_in(1, 5, 1, 5, 0, 0, 0);
        for (int c = 0; c < 9; c++) tick();
        check("stall_sat", 16'(stall_cycles), 16'(SAT));

        // Randomized run against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [5:0] ctl;
            if (m_fault && $urandom_range(0, 3) == 0) begin
                do_reset();
            end
            set_in(1'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 3) == 0, 1'($urandom),
                   $urandom_range(0, 3) != 0);
            #3;
            check($sformatf("rand%0d", c), 16'(snap()), 16'(model_snap()));
            ctl = model_ctl();
            tick();
            model_step(ctl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
